// File: rtl/spi_burst_transmitter.sv
// Burst-write feeder for spi_master: buffers words in a FIFO and
// streams one word per burst_data_ready pulse once a burst is launched.
module spi_burst_transmitter #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 15,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            write_enable,
    input  logic [DATA_WIDTH-1:0]           write_data,
    input  logic                            start,
    input  logic [ADDRESS_WIDTH-1:0]        start_address,
    input  logic [15:0]                     burst_count,
    input  logic                            spi_busy,
    input  logic                            spi_burst_data_ready,
    output logic                            spi_enable,
    output logic                            spi_burst_enable,
    output logic                            spi_read_write,
    output logic [ADDRESS_WIDTH-1:0]        spi_address,
    output logic [15:0]                     spi_burst_count,
    output logic [DATA_WIDTH-1:0]           spi_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            fifo_full,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        STREAM,
        WAIT_DONE
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]           read_pointer;
    logic [PW-1:0]           write_pointer;
    logic [15:0]             remaining;
    logic                    pop;
    logic                    push;
    logic                    overflow;
    logic                    start_ok;
    logic                    start_bad;

    assign spi_read_write = 1'b0;
    assign spi_data       = mem[read_pointer];
    assign fifo_full      = (fifo_level == LW'(FIFO_DEPTH));

    // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then
    assign pop       = (state == STREAM) && spi_burst_data_ready && (remaining != 16'd0);
    assign push      = write_enable && (!fifo_full || pop);
    assign overflow  = write_enable && fifo_full && !pop;
    assign start_ok  = start && (state == IDLE) && (burst_count != 16'd0)
                       && (burst_count <= 16'(fifo_level));
    assign start_bad = start && (state == IDLE) && !start_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            write_pointer <= '0;
            read_pointer  <= '0;
            fifo_level    <= '0;
        end else begin
            if (push) begin
                mem[write_pointer] <= write_data;
                write_pointer      <= write_pointer + 1'b1;
            end
            if (pop) read_pointer <= read_pointer + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            remaining        <= '0;
            spi_address      <= '0;
            spi_burst_count  <= '0;
            spi_enable       <= 1'b0;
            spi_burst_enable <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= overflow || start_bad;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        spi_address      <= start_address;
                        spi_burst_count  <= burst_count;
                        remaining        <= burst_count;
                        spi_enable       <= 1'b1;
                        spi_burst_enable <= 1'b1;
                        busy             <= 1'b1;
                        state            <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (spi_busy) begin
                        spi_enable <= 1'b0;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (pop) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            spi_burst_enable <= 1'b0;
                            state            <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!spi_busy) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_transmitter.sv
// Bench for spi_burst_transmitter: start-acceptance table, directed
// corner sequences and randomized bursts against a queue model.
module tb_spi_burst_transmitter;

    localparam int D = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [15:0] write_data;
    logic        start;
    logic [14:0] start_address;
    logic [15:0] burst_count;
    logic        spi_busy;
    logic        spi_burst_data_ready;
    logic        spi_enable;
    logic        spi_burst_enable;
    logic        spi_read_write;
    logic [14:0] spi_address;
    logic [15:0] spi_burst_count;
    logic [15:0] spi_data;
    logic [4:0]  fifo_level;
    logic        fifo_full;
    logic        busy;
    logic        done;
    logic        error;

    spi_burst_transmitter dut (
        .clock                (clock),
        .reset                (reset),
        .write_enable         (write_enable),
        .write_data           (write_data),
        .start                (start),
        .start_address        (start_address),
        .burst_count          (burst_count),
        .spi_busy             (spi_busy),
        .spi_burst_data_ready (spi_burst_data_ready),
        .spi_enable           (spi_enable),
        .spi_burst_enable     (spi_burst_enable),
        .spi_read_write       (spi_read_write),
        .spi_address          (spi_address),
        .spi_burst_count      (spi_burst_count),
        .spi_data             (spi_data),
        .fifo_level           (fifo_level),
        .fifo_full            (fifo_full),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model[$];

    typedef struct {
        int n_push;
        int count;
        bit exp_err;
        bit exp_en;
    } start_vec_t;

    start_vec_t tbl[6];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset                = 1'b1;
        write_enable         = 1'b0;
        write_data           = '0;
        start                = 1'b0;
        start_address        = '0;
        burst_count          = '0;
        spi_busy             = 1'b0;
        spi_burst_data_ready = 1'b0;
        step();
        reset = 1'b0;
        model.delete();
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_enable"}, spi_enable, 0);
        check({tag, "_burst_enable"}, spi_burst_enable, 0);
        check({tag, "_read_write"}, spi_read_write, 0);
        check({tag, "_address"}, spi_address, 0);
        check({tag, "_count"}, spi_burst_count, 0);
        check({tag, "_data"}, spi_data, 0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_full"}, fifo_full, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    task automatic push(logic [15:0] w);
        bit ovf;
        ovf          = (model.size() >= D);
        write_enable = 1'b1;
        write_data   = w;
        step();
        write_enable = 1'b0;
        if (!ovf) model.push_back(w);
        check("push_error", error, 32'(ovf));
        check("push_level", fifo_level, model.size());
        check("push_full", fifo_full, 32'(model.size() == D));
    endtask

    // push_at: index of the ready pulse that carries a concurrent push
    task automatic run_burst(int cnt, logic [14:0] addr, int push_at, logic [15:0] pword);
        start         = 1'b1;
        burst_count   = 16'(cnt);
        start_address = addr;
        step();
        start = 1'b0;
        check("launch_enable", spi_enable, 1);
        check("launch_burst_en", spi_burst_enable, 1);
        check("launch_busy", busy, 1);
        check("launch_error", error, 0);
        check("launch_address", spi_address, addr);
        check("launch_count", spi_burst_count, cnt);
        repeat ($urandom_range(0, 2)) step();
        spi_burst_data_ready = 1'b1;
        step();
        spi_burst_data_ready = 1'b0;
        check("launch_hold", spi_enable, 1);
        check("stray_ready_data", spi_data, model[0]);
        check("stray_ready_level", fifo_level, model.size());
        spi_busy = 1'b1;
        step();
        check("stream_enable", spi_enable, 0);
        check("stream_burst_en", spi_burst_enable, 1);
        for (int i = 0; i < cnt; i++) begin
            check("spi_data", spi_data, model[0]);
            repeat ($urandom_range(0, 2)) step();
            check("data_stable", spi_data, model[0]);
            spi_burst_data_ready = 1'b1;
            if (i == push_at) begin
                write_enable = 1'b1;
                write_data   = pword;
            end
            step();
            spi_burst_data_ready = 1'b0;
            write_enable         = 1'b0;
            void'(model.pop_front());
            if (i == push_at) model.push_back(pword);
            check("pop_level", fifo_level, model.size());
        end
        check("wait_burst_en", spi_burst_enable, 0);
        check("wait_busy", busy, 1);
        check("wait_done", done, 0);
        repeat ($urandom_range(0, 3)) step();
        check("wait_hold", busy, 1);
        spi_busy = 1'b0;
        step();
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        step();
        check("done_single", done, 0);
    endtask

    initial begin
        tbl[0] = '{n_push: 2,  count: 3,  exp_err: 1'b1, exp_en: 1'b0};
        tbl[1] = '{n_push: 2,  count: 0,  exp_err: 1'b1, exp_en: 1'b0};
        tbl[2] = '{n_push: 2,  count: 2,  exp_err: 1'b0, exp_en: 1'b1};
        tbl[3] = '{n_push: 16, count: 16, exp_err: 1'b0, exp_en: 1'b1};
        tbl[4] = '{n_push: 0,  count: 1,  exp_err: 1'b1, exp_en: 1'b0};
        tbl[5] = '{n_push: 5,  count: 1,  exp_err: 1'b0, exp_en: 1'b1};

        do_reset();
        check_all_zero("reset");

        foreach (tbl[k]) begin
            do_reset();
            for (int j = 0; j < tbl[k].n_push; j++) push(16'($urandom));
            start       = 1'b1;
            burst_count = 16'(tbl[k].count);
            step();
            start = 1'b0;
            check("tbl_error", error, 32'(tbl[k].exp_err));
            check("tbl_enable", spi_enable, 32'(tbl[k].exp_en));
            check("tbl_busy", busy, 32'(tbl[k].exp_en));
            step();
            check("tbl_error_single", error, 0);
        end

        // basic burst
        do_reset();
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        run_burst(3, 15'h1111, -1, 16'h0);
        check("basic_level", fifo_level, 0);

        // overflow then full-depth burst
        do_reset();
        for (int j = 1; j <= 17; j++) push(16'(j));
        check("ovf_full", fifo_full, 1);
        step();
        check("ovf_error_single", error, 0);
        run_burst(16, 15'h0042, -1, 16'h0);
        check("ovf_drained", fifo_level, 0);

        // concurrent push during a pop
        do_reset();
        for (int j = 0; j < 4; j++) push(16'h0100 + 16'(j));
        run_burst(4, 15'h0007, 1, 16'hAAAA);
        check("conc_level", fifo_level, 1);
        check("conc_data", spi_data, 16'hAAAA);

        // pointer wrap with three 6-word bursts
        do_reset();
        for (int j = 0; j < 10; j++) push(16'h5000 + 16'(j));
        run_burst(6, 15'h0100, -1, 16'h0);
        for (int j = 10; j < 18; j++) push(16'h5000 + 16'(j));
        run_burst(6, 15'h0200, -1, 16'h0);
        run_burst(6, 15'h0300, -1, 16'h0);
        check("wrap_level", fifo_level, 0);

        // reset in the middle of a stream
        do_reset();
        for (int j = 0; j < 5; j++) push(16'h7000 + 16'(j));
        start         = 1'b1;
        burst_count   = 16'd5;
        start_address = 15'h0abc;
        step();
        start    = 1'b0;
        spi_busy = 1'b1;
        step();
        repeat (2) begin
            spi_burst_data_ready = 1'b1;
            step();
            spi_burst_data_ready = 1'b0;
            step();
        end
        check("mid_data", spi_data, 16'h7002);
        reset = 1'b1;
        step();
        check_all_zero("midreset");
        reset    = 1'b0;
        spi_busy = 1'b0;
        model.delete();
        push(16'hBEEF);
        run_burst(1, 15'h0001, -1, 16'h0);
        check("post_reset_level", fifo_level, 0);

        // randomized traffic
        do_reset();
        repeat (25) begin
            repeat ($urandom_range(0, 8)) push(16'($urandom));
            if (model.size() < D && $urandom_range(0, 3) == 0) begin
                start       = 1'b1;
                burst_count = 16'(model.size() + 1);
                step();
                start = 1'b0;
                check("rand_reject_err", error, 1);
                check("rand_reject_busy", busy, 0);
            end
            if (model.size() > 0) begin
                int cnt;
                cnt = $urandom_range(1, model.size());
                run_burst(cnt, 15'($urandom), $urandom_range(0, cnt),
                          16'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
